// File: rtl/nios2_qsys_pio_pkg.sv
// Shared constants for the key PIO: register word addresses, edge-select
// encodings and a constant clog2 used to size the debounce counters.
package nios2_qsys_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RAW     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nios2_qsys_pio_key_debounce.sv
// One key channel: SYNC_STAGES-deep synchroniser followed by a counter
// debounce that only accepts a new level after DEBOUNCE_CYCLES stable samples.
module nios2_qsys_pio_key_debounce
   import nios2_qsys_pio_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic sync_out,
   output logic deb_out
);

   // A one-cycle filter still needs a 1-bit counter to keep the logic uniform.
   localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   deb_q, deb_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin};
      deb_d  = deb_q;
      cnt_d  = '0;
      if (sync_q[SYNC_STAGES-1] != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync_q[SYNC_STAGES-1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
         deb_q  <= IDLE_LEVEL;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign deb_out  = deb_q;

endmodule

// File: rtl/nios2_qsys_pio_key_irq.sv
// Avalon-MM key PIO with per-channel debounce, sticky edge capture and a
// masked level interrupt. Read data is registered (latency 1).
module nios2_qsys_pio_key_irq
   import nios2_qsys_pio_pkg::*;
#(
   parameter int   WIDTH           = 8,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1,
   parameter int   EDGE_TYPE       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] rise, fall, edge_sel, clr;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      nios2_qsys_pio_key_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .pin     (in_port[i]),
         .sync_out(sync_in[i]),
         .deb_out (deb[i])
      );
   end

   always_comb begin
      wr_en     = chipselect & ~write_n;
      deb_dly_d = deb;
      rise      = deb & ~deb_dly_q;
      fall      = ~deb & deb_dly_q;
      if (EDGE_TYPE == EDGE_RISE)      edge_sel = rise;
      else if (EDGE_TYPE == EDGE_FALL) edge_sel = fall;
      else                             edge_sel = rise | fall;

      irqmask_d = irqmask_q;
      if (wr_en && (address == ADDR_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];

      // A new edge in the same cycle as a write-1-clear keeps the bit set.
      clr       = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
      edgecap_d = (edgecap_q & ~clr) | edge_sel;

      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d = 32'(deb);
         ADDR_RAW:     readdata_d = 32'(sync_in);
         ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
         default:      readdata_d = 32'(edgecap_q);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_dly_q  <= {WIDTH{IDLE_LEVEL}};
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         deb_dly_q  <= deb_dly_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign unused_wdata = ^writedata;
   assign readdata     = readdata_q;
   assign irq          = |(edgecap_q & irqmask_q);

endmodule
